// File: rtl/cic_pkg.sv
// Shared constants, state encoding and ratio range helper for the CIC decimator controller.
package cic_pkg;

    localparam int NUM_STAGES    = 3;
    localparam int RATIO_W       = 6;
    localparam int RATIO_MIN     = 2;
    // Decimator bit growth is fixed at 5 bits per stage, so 32 is the largest usable ratio.
    localparam int RATIO_MAX     = 32;
    localparam int DEFAULT_RATIO = 32;
    localparam int FLUSH_CYC     = NUM_STAGES + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } cic_state_t;

    function automatic logic ratio_in_range(input int r);
        return (r >= RATIO_MIN) && (r <= RATIO_MAX);
    endfunction

endpackage

// File: rtl/cic_strobe_gen.sv
// Decimation strobe generator: down-counter reloaded with ratio-1, one-cycle strobe at terminal count.
module cic_strobe_gen #(
    parameter int RATIO_W = cic_pkg::RATIO_W
) (
    input  logic               in_clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               load,
    input  logic [RATIO_W-1:0] ratio,
    output logic               strobe
);

    logic [RATIO_W-1:0] r_cnt;
    logic               r_strobe;
    logic [RATIO_W-1:0] w_reload;

    assign w_reload = ratio - RATIO_W'(1);

    // Count down while enabled; strobe and reload on terminal count so the period is exactly ratio.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (!en) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (load) begin
            r_cnt    <= w_reload;
            r_strobe <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt    <= w_reload;
            r_strobe <= 1'b1;
        end else begin
            r_cnt    <= r_cnt - RATIO_W'(1);
            r_strobe <= 1'b0;
        end
    end

    assign strobe = r_strobe;

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencing controller: flush, warm-up discard, then qualified run.
//
// state  | meaning
// IDLE   | decimator held in reset, waiting for enable and synchronized reset release
// FLUSH  | reset held FLUSH_CYC cycles to clear the comb-enable pipeline
// WARMUP | strobes running, first NUM_STAGES decimator outputs discarded
// RUN    | strobes running, decimator outputs forwarded one cycle later
module cic_decim_ctrl #(
    parameter int NUM_STAGES    = cic_pkg::NUM_STAGES,
    parameter int RATIO_W       = cic_pkg::RATIO_W,
    parameter int DEFAULT_RATIO = cic_pkg::DEFAULT_RATIO
) (
    input  logic               in_clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_load,
    input  logic               cic_valid_in,
    output logic               cic_reset,
    output logic               cic_out_clk,
    output logic               out_valid,
    output logic               busy,
    output logic               cfg_err,
    output logic [RATIO_W-1:0] ratio
);

    import cic_pkg::cic_state_t, cic_pkg::ST_IDLE, cic_pkg::ST_FLUSH,
           cic_pkg::ST_WARMUP, cic_pkg::ST_RUN, cic_pkg::ratio_in_range;

    localparam int FLUSH_LEN = NUM_STAGES + 2;
    localparam int FW        = $clog2(FLUSH_LEN + 1);
    localparam int WW        = $clog2(NUM_STAGES + 1);

    cic_state_t         r_state;
    cic_state_t         w_state_nxt;
    logic [1:0]         r_rst_sync;
    logic [FW-1:0]      r_flush_cnt;
    logic [WW-1:0]      r_warm_cnt;
    logic [RATIO_W-1:0] r_ratio;
    logic               r_cic_reset;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_cfg_err;

    logic w_run_ok;
    logic w_ratio_ok;
    logic w_accept;
    logic w_reject;
    logic w_flush_done;
    logic w_warm_done;
    logic w_cic_reset_nxt;
    logic w_busy_nxt;
    logic w_out_valid_nxt;
    logic w_strobe_en;
    logic w_strobe_load;
    logic w_strobe;

    assign w_run_ok     = r_rst_sync[1];
    assign w_ratio_ok   = ratio_in_range(int'(cfg_ratio));
    assign w_accept     = cfg_load && w_ratio_ok;
    assign w_reject     = cfg_load && !w_ratio_ok;
    assign w_flush_done = (r_flush_cnt == '0);
    assign w_warm_done  = cic_valid_in && (r_warm_cnt == WW'(NUM_STAGES - 1));

    // Two-flop synchronizer on reset release; the FSM stays in IDLE until it settles.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // State register.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and next-output decode; enable low and accepted loads override the sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_cic_reset_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
        w_out_valid_nxt = 1'b0;
        if (!w_run_ok || !enable) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_FLUSH;
                ST_FLUSH:  if (w_flush_done) w_state_nxt = ST_WARMUP;
                ST_WARMUP: if (w_warm_done)  w_state_nxt = ST_RUN;
                ST_RUN:    w_state_nxt = ST_RUN;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
        w_cic_reset_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FLUSH);
        w_busy_nxt      = (w_state_nxt != ST_RUN);
        // The pulse that completes warm-up arrives while still in WARMUP and is dropped.
        w_out_valid_nxt = cic_valid_in && (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    end

    // Flush length counter; reloaded on FLUSH entry and on any accepted load during FLUSH.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_cnt <= '0;
        end else if (w_state_nxt == ST_FLUSH) begin
            if ((r_state != ST_FLUSH) || w_accept) r_flush_cnt <= FW'(FLUSH_LEN - 1);
            else                                   r_flush_cnt <= r_flush_cnt - FW'(1);
        end else begin
            r_flush_cnt <= '0;
        end
    end

    // Warm-up pulse counter; saturates and is cleared outside WARMUP.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_warm_cnt <= '0;
        end else if (w_state_nxt != ST_WARMUP) begin
            r_warm_cnt <= '0;
        end else if ((r_state == ST_WARMUP) && cic_valid_in &&
                     (r_warm_cnt != WW'(NUM_STAGES - 1))) begin
            r_warm_cnt <= r_warm_cnt + WW'(1);
        end
    end

    // Active ratio and sticky rejection flag.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ratio   <= RATIO_W'(DEFAULT_RATIO);
            r_cfg_err <= 1'b0;
        end else if (w_accept) begin
            r_ratio   <= cfg_ratio;
            r_cfg_err <= 1'b0;
        end else if (w_reject) begin
            r_cfg_err <= 1'b1;
        end
    end

    // Registered status outputs aligned with the state register.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cic_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_cic_reset <= w_cic_reset_nxt;
            r_busy      <= w_busy_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign w_strobe_en   = (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_RUN);
    assign w_strobe_load = (w_state_nxt == ST_WARMUP) && (r_state != ST_WARMUP);

    cic_strobe_gen #(
        .RATIO_W (RATIO_W)
    ) u_strobe_gen (
        .in_clk  (in_clk),
        .reset_n (reset_n),
        .en      (w_strobe_en),
        .load    (w_strobe_load),
        .ratio   (r_ratio),
        .strobe  (w_strobe)
    );

    assign cic_reset   = r_cic_reset;
    assign cic_out_clk = w_strobe;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign cfg_err     = r_cfg_err;
    assign ratio       = r_ratio;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl; the decimator is modelled as answering each strobe with a valid pulse.
module tb_cic_decim_ctrl;

    localparam int RW = 6;

    logic          in_clk       = 1'b0;
    logic          reset_n      = 1'b0;
    logic          enable       = 1'b0;
    logic          cfg_load     = 1'b0;
    logic          cic_valid_in = 1'b0;
    logic [RW-1:0] cfg_ratio    = '0;
    logic          cic_reset;
    logic          cic_out_clk;
    logic          out_valid;
    logic          busy;
    logic          cfg_err;
    logic [RW-1:0] ratio;

    int n_checks  = 0;
    int n_fail    = 0;
    int since     = -1;
    int last_gap  = 0;
    int first_gap = 0;
    int n_strobe  = 0;
    int n_ov      = 0;
    int c;

    cic_decim_ctrl dut (
        .in_clk       (in_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cfg_ratio    (cfg_ratio),
        .cfg_load     (cfg_load),
        .cic_valid_in (cic_valid_in),
        .cic_reset    (cic_reset),
        .cic_out_clk  (cic_out_clk),
        .out_valid    (out_valid),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .ratio        (ratio)
    );

    always #5 in_clk = ~in_clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: sample just after the edge, track strobe spacing, answer strobes with valid.
    task automatic tick();
        @(posedge in_clk);
        #1;
        if (cic_reset) begin
            since = -1;
        end else begin
            since++;
            if (cic_out_clk) begin
                last_gap = since;
                since    = 0;
                n_strobe++;
                if (n_strobe == 1) first_gap = last_gap;
            end
        end
        if (out_valid) n_ov++;
        cic_valid_in = cic_out_clk && !cic_reset;
    endtask

    task automatic pulse_load(input int val);
        cfg_ratio = RW'(val);
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    // Starts on a sample with cic_reset high; walks flush, warm-up and the first forwarded sample.
    task automatic measure_seq(input string tag, input int r, input int flush_exp);
        int n;
        int k;
        n = 0;
        while (cic_reset && n < 60) begin
            n++;
            tick();
        end
        check_val({tag, "_flush_len"}, n, flush_exp);
        n_strobe  = 0;
        n_ov      = 0;
        first_gap = 0;
        k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        check_val({tag, "_busy_fall"}, k, 3 * r + 1);
        check_val({tag, "_discarded"}, n_strobe, 3);
        check_val({tag, "_warm_ov"}, n_ov, 0);
        check_val({tag, "_first_strobe"}, first_gap, r);
        k = 0;
        while (!out_valid && k < 500) begin
            tick();
            k++;
        end
        check_val({tag, "_first_valid"}, k, r);
        check_val({tag, "_period"}, last_gap, r);
        tick();
        check_val({tag, "_valid_1cyc"}, out_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        check_val("rst_cic_reset", cic_reset, 1);
        check_val("rst_out_clk", cic_out_clk, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy", busy, 1);
        check_val("rst_cfg_err", cfg_err, 0);
        check_val("rst_ratio", ratio, 32);

        reset_n = 1'b1;
        repeat (3) tick();
        check_val("idle_hold_reset", cic_reset, 1);
        check_val("idle_busy", busy, 1);

        enable = 1'b1;
        tick();
        measure_seq("boot", 32, 5);

        // Rejected loads must leave ratio, state and strobe phase alone.
        c = 0;
        while (!cic_out_clk && c < 100) begin tick(); c++; end
        repeat (5) tick();
        pulse_load(1);
        check_val("rej1_err", cfg_err, 1);
        check_val("rej1_ratio", ratio, 32);
        check_val("rej1_busy", busy, 0);
        repeat (3) tick();
        pulse_load(33);
        check_val("rej33_err", cfg_err, 1);
        check_val("rej33_ratio", ratio, 32);
        c = 0;
        while (!cic_out_clk && c < 100) begin tick(); c++; end
        check_val("rej_phase", last_gap, 32);

        pulse_load(16);
        check_val("ld16_err", cfg_err, 0);
        check_val("ld16_ratio", ratio, 16);
        check_val("ld16_busy", busy, 1);
        measure_seq("r16", 16, 5);

        pulse_load(8);
        check_val("ld8_ratio", ratio, 8);
        check_val("ld8_busy", busy, 1);
        measure_seq("r8", 8, 5);

        // Drop enable the cycle before a strobe is due: no trailing strobe may appear.
        c = 0;
        while (!cic_out_clk && c < 100) begin tick(); c++; end
        repeat (7) tick();
        enable = 1'b0;
        tick();
        check_val("dis_out_clk", cic_out_clk, 0);
        check_val("dis_cic_reset", cic_reset, 1);
        check_val("dis_out_valid", out_valid, 0);
        check_val("dis_busy", busy, 1);
        n_strobe = 0;
        n_ov     = 0;
        repeat (4) tick();
        check_val("dis_no_strobe", n_strobe + n_ov, 0);

        // Re-enable, then an accepted load two cycles into FLUSH restarts the flush count.
        enable = 1'b1;
        tick();
        repeat (2) tick();
        pulse_load(8);
        measure_seq("restart", 8, 5);

        // Accepted load together with enable low.
        cfg_ratio = RW'(4);
        cfg_load  = 1'b1;
        enable    = 1'b0;
        tick();
        cfg_load  = 1'b0;
        check_val("ld4dis_ratio", ratio, 4);
        check_val("ld4dis_cic_reset", cic_reset, 1);
        check_val("ld4dis_busy", busy, 1);
        repeat (3) tick();
        check_val("ld4dis_idle", cic_reset, 1);
        pulse_load(40);
        check_val("rej40_err", cfg_err, 1);
        check_val("rej40_ratio", ratio, 4);

        // Reset pulse in the middle of WARMUP.
        enable = 1'b1;
        tick();
        repeat (7) tick();
        check_val("warm_mid_reset", cic_reset, 0);
        check_val("warm_mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check_val("arst_cic_reset", cic_reset, 1);
        check_val("arst_out_clk", cic_out_clk, 0);
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_busy", busy, 1);
        check_val("arst_cfg_err", cfg_err, 0);
        check_val("arst_ratio", ratio, 32);
        #2;
        reset_n = 1'b1;
        tick();
        measure_seq("rst_rel", 32, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
